// File: rtl/arm_ctrl_pkg.sv
// arm_ctrl_pkg: shared encodings and decode helpers for the ID-stage control unit.
package arm_ctrl_pkg;
    localparam logic [1:0] MODE_DP  = 2'b00;
    localparam logic [1:0] MODE_MEM = 2'b01;
    localparam logic [1:0] MODE_BR  = 2'b10;
    localparam logic [1:0] MODE_CP  = 2'b11;
    localparam logic [3:0] OP_AND = 4'b0000, OP_EOR = 4'b0001, OP_SUB = 4'b0010, OP_ADD = 4'b0100;
    localparam logic [3:0] OP_ADC = 4'b0101, OP_SBC = 4'b0110, OP_TST = 4'b1000, OP_CMP = 4'b1010;
    localparam logic [3:0] OP_ORR = 4'b1100, OP_MOV = 4'b1101, OP_MVN = 4'b1111;
    localparam logic [3:0] ALU_MOV = 4'b0001, ALU_ADD = 4'b0010, ALU_ADC = 4'b0011, ALU_SUB = 4'b0100;
    localparam logic [3:0] ALU_SBC = 4'b0101, ALU_AND = 4'b0110, ALU_ORR = 4'b0111, ALU_EOR = 4'b1000;
    localparam logic [3:0] ALU_MVN = 4'b1001, MUL_ALU = 4'b1010;
    localparam logic [3:0] COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF;
    localparam int N_BIT = 3, Z_BIT = 2, C_BIT = 1, V_BIT = 0;

    typedef enum logic {IDLE, MULTI} state_t;

    typedef struct packed {
        logic       valid;
        logic [3:0] cmd;
        logic       s;
        logic       b;
        logic       mem_w;
        logic       mem_r;
        logic       wb;
    } ctrl_t;

    // {wb_en, alu_cmd}; an all-zero result marks an undefined opcode (NOP)
    function automatic logic [4:0] dp_decode(input logic [3:0] op);
        case (op)
            OP_MOV:  return {1'b1, ALU_MOV};
            OP_MVN:  return {1'b1, ALU_MVN};
            OP_ADD:  return {1'b1, ALU_ADD};
            OP_ADC:  return {1'b1, ALU_ADC};
            OP_SUB:  return {1'b1, ALU_SUB};
            OP_SBC:  return {1'b1, ALU_SBC};
            OP_AND:  return {1'b1, ALU_AND};
            OP_ORR:  return {1'b1, ALU_ORR};
            OP_EOR:  return {1'b1, ALU_EOR};
            OP_CMP:  return {1'b0, ALU_SUB};
            OP_TST:  return {1'b0, ALU_AND};
            default: return 5'b0;
        endcase
    endfunction
endpackage

// File: rtl/cond_check.sv
// cond_check: combinational ARM condition-field evaluation against NZCV.
module cond_check
    import arm_ctrl_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] status,
    output logic       pass
);
    logic n, z, c, v;
    assign n = status[N_BIT];
    assign z = status[Z_BIT];
    assign c = status[C_BIT];
    assign v = status[V_BIT];
    always_comb begin
        pass = 1'b0;
        case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = !z;
            COND_CS: pass = c;
            COND_CC: pass = !c;
            COND_MI: pass = n;
            COND_PL: pass = !n;
            COND_VS: pass = v;
            COND_VC: pass = !v;
            COND_HI: pass = c && !z;
            COND_LS: pass = !c || z;
            COND_GE: pass = n == v;
            COND_LT: pass = n != v;
            COND_GT: pass = !z && (n == v);
            COND_LE: pass = z || (n != v);
            COND_AL: pass = 1'b1;
            COND_NV: pass = 1'b0;
            default: pass = 1'b0;
        endcase
    end
endmodule

// File: rtl/pipelined_control_unit.sv
// pipelined_control_unit: registered ID/EX control stage with stall, flush and multi-cycle MUL.
module pipelined_control_unit
    import arm_ctrl_pkg::*;
#(
    parameter int CMD_W      = 4,
    parameter int MUL_CYCLES = 3,
    parameter int ENABLE_MUL = 1,
    parameter int COND_EN    = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       cond,
    input  logic [1:0]       mode,
    input  logic [3:0]       opcode,
    input  logic             s_in,
    input  logic             mul_hint,
    input  logic [3:0]       status,
    input  logic             hazard,
    input  logic             flush,
    output logic             out_valid,
    output logic [CMD_W-1:0] exe_cmd,
    output logic             s_out,
    output logic             b,
    output logic             mem_w_en,
    output logic             mem_r_en,
    output logic             wb_en,
    output logic             busy
);
    state_t     state;
    logic [3:0] cnt;
    logic       s_lat, cond_pass, pass, is_mul, accept;
    logic [4:0] dp;
    ctrl_t      q, dec, mul_ctrl;

    cond_check u_cond (.cond(cond), .status(status), .pass(cond_pass));

    assign pass     = (COND_EN == 0) || cond_pass;
    assign in_ready = (state == IDLE) && !hazard && !flush;
    assign accept   = in_valid && in_ready;
    assign dp       = dp_decode(opcode);
    assign is_mul   = (ENABLE_MUL != 0) && (mode == MODE_DP) && mul_hint;
    assign mul_ctrl = '{valid: 1'b1, cmd: MUL_ALU, s: s_lat, b: 1'b0, mem_w: 1'b0, mem_r: 1'b0, wb: 1'b1};

    // A failed condition still occupies the slot but drives no side effects
    always_comb begin
        dec = '0;
        dec.valid = 1'b1;
        if (pass)
            case (mode)
                MODE_DP: begin
                    dec.cmd = is_mul ? MUL_ALU : dp[3:0];
                    dec.wb  = is_mul || dp[4];
                    dec.s   = s_in && (is_mul || dp[3:0] != 4'b0);
                end
                MODE_MEM: begin
                    dec.cmd   = ALU_ADD;
                    dec.mem_r = s_in;
                    dec.mem_w = !s_in;
                    dec.wb    = s_in;
                end
                MODE_BR: dec.b = 1'b1;
                MODE_CP: ;
            endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
            busy  <= 1'b0;
            s_lat <= 1'b0;
            q     <= '0;
        end else if (flush) begin
            state <= IDLE;
            cnt   <= 4'd0;
            busy  <= 1'b0;
            q     <= '0;
        end else if (hazard) begin
            q <= '0;
        end else if (state == MULTI) begin
            q     <= (cnt == 4'd1) ? mul_ctrl : '0;
            state <= (cnt == 4'd1) ? IDLE : MULTI;
            busy  <= cnt != 4'd1;
            cnt   <= cnt - 4'd1;
        end else if (accept && is_mul && pass && MUL_CYCLES > 1) begin
            state <= MULTI;
            cnt   <= 4'(MUL_CYCLES - 1);
            busy  <= 1'b1;
            s_lat <= s_in;
            q     <= '0;
        end else begin
            q <= accept ? dec : '0;
        end
    end

    assign out_valid = q.valid;
    assign exe_cmd   = CMD_W'(q.cmd);
    assign s_out     = q.s;
    assign b         = q.b;
    assign mem_w_en  = q.mem_w;
    assign mem_r_en  = q.mem_r;
    assign wb_en     = q.wb;
endmodule

// File: tb/tb_pipelined_control_unit.sv
// tb_pipelined_control_unit: vector table, directed corner sequences and randomized model comparison.
module tb_pipelined_control_unit;
    localparam int MC = 3;
    logic clk = 1'b0, rst;
    logic in_valid, in_ready, s_in, mul_hint, hazard, flush;
    logic [3:0] cond, opcode, status, exe_cmd;
    logic [1:0] mode;
    logic out_valid, s_out, b, mem_w_en, mem_r_en, wb_en, busy;
    int n_cmp = 0, n_bad = 0;
    int alu[16];

    pipelined_control_unit #(.CMD_W(4), .MUL_CYCLES(MC), .ENABLE_MUL(1), .COND_EN(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .cond(cond),
        .mode(mode), .opcode(opcode), .s_in(s_in), .mul_hint(mul_hint), .status(status),
        .hazard(hazard), .flush(flush), .out_valid(out_valid), .exe_cmd(exe_cmd),
        .s_out(s_out), .b(b), .mem_w_en(mem_w_en), .mem_r_en(mem_r_en), .wb_en(wb_en), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  c;
        logic [1:0]  m;
        logic [3:0]  op;
        logic        s;
        logic        mh;
        logic [3:0]  st;
        logic [10:0] exp;
    } vec_t;
    vec_t tbl[16];

    function automatic logic [10:0] outs();
        return {out_valid, exe_cmd, s_out, b, mem_w_en, mem_r_en, wb_en, busy};
    endfunction

    task automatic chk(input string nm, input logic [10:0] got, input logic [10:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", nm, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] c, input logic [1:0] m, input logic [3:0] op,
                         input logic s, input logic mh, input logic [3:0] st, input logic hz, input logic fl);
        in_valid = v; cond = c; mode = m; opcode = op; s_in = s; mul_hint = mh;
        status = st; hazard = hz; flush = fl;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ARM conditions come in pairs: even code tests a predicate, odd code its negation
    function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
        bit base;
        case (c[3:1])
            3'd0: base = f[2];
            3'd1: base = f[1];
            3'd2: base = f[3];
            3'd3: base = f[0];
            3'd4: base = f[1] && !f[2];
            3'd5: base = f[3] == f[0];
            3'd6: base = !f[2] && (f[3] == f[0]);
            default: base = 1'b1;
        endcase
        return c[0] ? !base : base;
    endfunction

    function automatic logic [10:0] model(input logic [3:0] c, input logic [1:0] m, input logic [3:0] op,
                                          input logic s, input logic mh, input logic [3:0] st);
        logic [3:0] cmd;
        if (!cond_ok(c, st)) return 11'b10000000000;
        case (m)
            2'd0: begin
                if (mh) return {1'b1, 4'b1010, s, 5'b00010};
                cmd = 4'(alu[op]);
                if (cmd == 4'd0) return 11'b10000000000;
                return {1'b1, cmd, s, 3'b000, !(op == 4'd8 || op == 4'd10), 1'b0};
            end
            2'd1: return s ? 11'b10010000110 : 11'b10010001000;
            2'd2: return 11'b10000010000;
            default: return 11'b10000000000;
        endcase
    endfunction

    initial begin
        int mul_left;
        bit mul_s;
        logic [10:0] exp;
        foreach (alu[i]) alu[i] = 0;
        alu[13] = 1; alu[15] = 9; alu[4] = 2; alu[5] = 3; alu[2] = 4; alu[6] = 5;
        alu[0] = 6; alu[12] = 7; alu[1] = 8; alu[10] = 4; alu[8] = 6;
        tbl[0]  = '{4'hE, 2'd0, 4'b0100, 1'b1, 1'b0, 4'b0000, 11'b10010100010};
        tbl[1]  = '{4'h0, 2'd0, 4'b0010, 1'b1, 1'b0, 4'b0000, 11'b10000000000};
        tbl[2]  = '{4'h0, 2'd0, 4'b0010, 1'b0, 1'b0, 4'b0100, 11'b10100000010};
        tbl[3]  = '{4'hE, 2'd0, 4'b1010, 1'b1, 1'b0, 4'b0000, 11'b10100100000};
        tbl[4]  = '{4'hE, 2'd0, 4'b1000, 1'b1, 1'b0, 4'b0000, 11'b10110100000};
        tbl[5]  = '{4'hE, 2'd0, 4'b1111, 1'b0, 1'b0, 4'b0000, 11'b11001000010};
        tbl[6]  = '{4'hE, 2'd1, 4'b0000, 1'b1, 1'b0, 4'b0000, 11'b10010000110};
        tbl[7]  = '{4'hE, 2'd1, 4'b0000, 1'b0, 1'b0, 4'b0000, 11'b10010001000};
        tbl[8]  = '{4'hE, 2'd2, 4'b0000, 1'b1, 1'b0, 4'b0000, 11'b10000010000};
        tbl[9]  = '{4'hE, 2'd3, 4'b0100, 1'b1, 1'b0, 4'b0000, 11'b10000000000};
        tbl[10] = '{4'hE, 2'd0, 4'b0011, 1'b1, 1'b0, 4'b0000, 11'b10000000000};
        tbl[11] = '{4'hF, 2'd0, 4'b0100, 1'b1, 1'b0, 4'b0000, 11'b10000000000};
        tbl[12] = '{4'hC, 2'd0, 4'b1100, 1'b0, 1'b0, 4'b1001, 11'b10111000010};
        tbl[13] = '{4'hD, 2'd0, 4'b0100, 1'b0, 1'b0, 4'b1001, 11'b10000000000};
        tbl[14] = '{4'h8, 2'd0, 4'b0001, 1'b0, 1'b0, 4'b0010, 11'b11000000010};
        tbl[15] = '{4'h1, 2'd0, 4'b0000, 1'b1, 1'b1, 4'b0100, 11'b10000000000};

        rst = 1'b1;
        drive(0, 4'hE, 2'd0, 4'd0, 0, 0, 4'd0, 0, 0);
        #12;
        chk("reset_outs", outs(), 11'd0);
        rst = 1'b0;
        #1;
        chk("reset_ready", {10'd0, in_ready}, 11'd1);

        for (int i = 0; i < 16; i++) begin
            drive(1, tbl[i].c, tbl[i].m, tbl[i].op, tbl[i].s, tbl[i].mh, tbl[i].st, 0, 0);
            step();
            chk($sformatf("vec%0d", i), outs(), tbl[i].exp);
        end

        // MUL occupies EX for three edges; an ADD offered meanwhile waits
        drive(1, 4'hE, 2'd0, 4'd0, 1, 1, 4'd0, 0, 0);
        step();
        chk("mul_busy1", outs(), 11'b00000000001);
        drive(1, 4'hE, 2'd0, 4'b0100, 0, 0, 4'd0, 0, 0);
        #1 chk("mul_ready1", {10'd0, in_ready}, 11'd0);
        step();
        chk("mul_busy2", outs(), 11'b00000000001);
        chk("mul_ready2", {10'd0, in_ready}, 11'd0);
        step();
        chk("mul_emit", outs(), 11'b11010100010);
        chk("mul_ready3", {10'd0, in_ready}, 11'd1);
        step();
        chk("mul_then_add", outs(), 11'b10010000010);

        drive(1, 4'hE, 2'd1, 4'd0, 1, 0, 4'd0, 1, 0);
        #1 chk("hz_ready", {10'd0, in_ready}, 11'd0);
        step();
        chk("hz_bubble1", outs(), 11'd0);
        step();
        chk("hz_bubble2", outs(), 11'd0);
        hazard = 1'b0;
        step();
        chk("hz_ldr", outs(), 11'b10010000110);

        drive(1, 4'hE, 2'd0, 4'd0, 1, 1, 4'd0, 0, 0);
        step();
        drive(0, 4'hE, 2'd0, 4'd0, 1, 1, 4'd0, 0, 0);
        step();
        chk("fl_busy", outs(), 11'b00000000001);
        hazard = 1'b1; flush = 1'b1;
        step();
        chk("fl_abort", outs(), 11'd0);
        hazard = 1'b0; flush = 1'b0;
        #1 chk("fl_ready", {10'd0, in_ready}, 11'd1);
        step();
        chk("fl_no_mul1", outs(), 11'd0);
        step();
        chk("fl_no_mul2", outs(), 11'd0);

        drive(1, 4'hE, 2'd0, 4'd0, 1, 1, 4'd0, 0, 0);
        step();
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1 chk("rst_async", outs(), 11'd0);
        #2 rst = 1'b0;
        drive(1, 4'hE, 2'd2, 4'd0, 0, 0, 4'd0, 0, 0);
        step();
        chk("rst_then_b", outs(), 11'b10000010000);
        in_valid = 1'b0;
        step();
        chk("rst_no_mul", outs(), 11'd0);

        mul_left = 0;
        mul_s = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 9) < 7, ($urandom_range(0, 1) == 1) ? 4'hE : 4'($urandom),
                  2'($urandom), 4'($urandom), 1'($urandom), $urandom_range(0, 9) < 3,
                  4'($urandom), $urandom_range(0, 9) < 2, $urandom_range(0, 19) < 1);
            #1 chk("rnd_ready", {10'd0, in_ready}, {10'd0, mul_left == 0 && !hazard && !flush});
            if (flush) begin
                mul_left = 0;
                exp = 11'd0;
            end else if (hazard) begin
                exp = {10'd0, mul_left > 0};
            end else if (mul_left > 0) begin
                mul_left--;
                exp = (mul_left == 0) ? {1'b1, 4'b1010, mul_s, 5'b00010} : 11'd1;
            end else if (in_valid) begin
                if (mul_hint && mode == 2'd0 && cond_ok(cond, status)) begin
                    mul_left = MC - 1;
                    mul_s = s_in;
                    exp = 11'd1;
                end else begin
                    exp = model(cond, mode, opcode, s_in, mul_hint && mode == 2'd0, status);
                end
            end else begin
                exp = 11'd0;
            end
            step();
            chk($sformatf("rnd%0d", i), outs(), exp);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
